// File: rtl/matinv_pkg.sv
// Shared constants, FSM state encoding and output saturation for the 3x3 adjugate inverter.
package matinv_pkg;

  localparam int FRAC_BITS = 12;
  localparam int DIV_ITERS = 25;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COF,
    S_DET,
    S_DIV,
    S_SCALE
  } state_t;

  function automatic logic signed [15:0] sat16(input logic signed [64:0] x);
    if (x > 65'sd32767) return 16'h7FFF;
    if (x < -65'sd32768) return 16'h8000;
    return x[15:0];
  endfunction

endpackage

// File: rtl/recip_div.sv
// Restoring divider computing 2^24 / divisor, one quotient bit per cycle, MSB first.
module recip_div
  import matinv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic        ready
);

  logic [31:0]          rem_q;
  logic [31:0]          quo_q;
  logic [31:0]          dvs_q;
  logic [DIV_ITERS-1:0] dvd_q;
  logic [4:0]           cnt_q;
  logic [32:0]          shifted;
  logic [31:0]          trial;
  logic                 fits;

  assign shifted = {rem_q, dvd_q[DIV_ITERS-1]};
  assign fits    = shifted >= {1'b0, dvs_q};
  // Wraps correctly: whenever fits is set the true difference is below dvs_q.
  assign trial   = shifted[31:0] - dvs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dvd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= divisor;
      dvd_q <= {1'b1, {(DIV_ITERS-1){1'b0}}};
      cnt_q <= 5'(DIV_ITERS);
    end else if (cnt_q != '0) begin
      rem_q <= fits ? trial : shifted[31:0];
      quo_q <= {quo_q[30:0], fits};
      dvd_q <= {dvd_q[DIV_ITERS-2:0], 1'b0};
      cnt_q <= cnt_q - 5'd1;
    end
  end

  assign quotient = quo_q;
  // High during the final iteration; quotient is complete from the next cycle.
  assign ready    = (cnt_q == 5'd1);

endmodule

// File: rtl/matrix_inverse_adj.sv
// Sequential 3x3 Q4.12 inverter: cofactors, det, reciprocal, then one adjugate element per cycle.
// state   | meaning
// S_IDLE  | wait for valid; clears busy during the done cycle
// S_COF   | register the nine cofactors
// S_DET   | determinant; singular exit or start divider
// S_DIV   | reciprocal of |det| in progress
// S_SCALE | write I_ij = sat(C_ji * recip), one per cycle
module matrix_inverse_adj
  import matinv_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [W-1:0] A11,
  input  logic [W-1:0] A12,
  input  logic [W-1:0] A13,
  input  logic [W-1:0] A21,
  input  logic [W-1:0] A22,
  input  logic [W-1:0] A23,
  input  logic [W-1:0] A31,
  input  logic [W-1:0] A32,
  input  logic [W-1:0] A33,
  output logic [W-1:0] I11,
  output logic [W-1:0] I12,
  output logic [W-1:0] I13,
  output logic [W-1:0] I21,
  output logic [W-1:0] I22,
  output logic [W-1:0] I23,
  output logic [W-1:0] I31,
  output logic [W-1:0] I32,
  output logic [W-1:0] I33,
  output logic         done,
  output logic         busy,
  output logic         singular
);

  state_t              state_q;
  logic signed [W-1:0] a_in [9];
  logic signed [W-1:0] a_q  [9];
  logic signed [31:0]  c_d  [9];
  logic signed [31:0]  c_q  [9];
  logic signed [W-1:0] i_q  [9];
  logic                done_q, busy_q, sing_q, neg_q;
  logic [3:0]          k_q;

  logic signed [47:0]  det_acc;
  logic signed [31:0]  det_d;
  logic [31:0]         abs_det;
  logic                div_start, div_ready;
  logic [31:0]         quo;
  logic [3:0]          t_idx;
  logic signed [32:0]  recip;
  logic signed [64:0]  prod;
  logic signed [W-1:0] scaled;

  assign a_in[0] = A11;
  assign a_in[1] = A12;
  assign a_in[2] = A13;
  assign a_in[3] = A21;
  assign a_in[4] = A22;
  assign a_in[5] = A23;
  assign a_in[6] = A31;
  assign a_in[7] = A32;
  assign a_in[8] = A33;

  // The sign is applied after the shift, so negative minors round toward +inf when negated.
  function automatic logic signed [31:0] cof(input logic signed [W-1:0] p, q, r, s,
                                             input logic neg);
    logic signed [2*W:0] diff;
    logic signed [2*W:0] sh;
    diff = (2*W+1)'(p) * (2*W+1)'(q) - (2*W+1)'(r) * (2*W+1)'(s);
    sh   = diff >>> FRAC;
    return neg ? 32'(-sh) : 32'(sh);
  endfunction

  always_comb begin
    c_d[0] = cof(a_q[4], a_q[8], a_q[5], a_q[7], 1'b0);
    c_d[1] = cof(a_q[3], a_q[8], a_q[5], a_q[6], 1'b1);
    c_d[2] = cof(a_q[3], a_q[7], a_q[4], a_q[6], 1'b0);
    c_d[3] = cof(a_q[1], a_q[8], a_q[2], a_q[7], 1'b1);
    c_d[4] = cof(a_q[0], a_q[8], a_q[2], a_q[6], 1'b0);
    c_d[5] = cof(a_q[0], a_q[7], a_q[1], a_q[6], 1'b1);
    c_d[6] = cof(a_q[1], a_q[5], a_q[2], a_q[4], 1'b0);
    c_d[7] = cof(a_q[0], a_q[5], a_q[2], a_q[3], 1'b1);
    c_d[8] = cof(a_q[0], a_q[4], a_q[1], a_q[3], 1'b0);
  end

  assign det_acc = 48'(a_q[0]) * 48'(c_q[0]) + 48'(a_q[1]) * 48'(c_q[1])
                 + 48'(a_q[2]) * 48'(c_q[2]);
  assign det_d   = 32'(det_acc >>> FRAC);
  assign abs_det = det_d[31] ? 32'(-det_d) : 32'(det_d);

  assign div_start = (state_q == S_DET) && (det_d != '0);

  recip_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .divisor  (abs_det),
    .quotient (quo),
    .ready    (div_ready)
  );

  // Element k of I reads the transposed cofactor.
  always_comb begin
    t_idx = 4'd0;
    case (k_q)
      4'd0: t_idx = 4'd0;
      4'd1: t_idx = 4'd3;
      4'd2: t_idx = 4'd6;
      4'd3: t_idx = 4'd1;
      4'd4: t_idx = 4'd4;
      4'd5: t_idx = 4'd7;
      4'd6: t_idx = 4'd2;
      4'd7: t_idx = 4'd5;
      4'd8: t_idx = 4'd8;
      default: t_idx = 4'd0;
    endcase
  end

  assign recip  = neg_q ? -$signed({1'b0, quo}) : $signed({1'b0, quo});
  assign prod   = 65'(c_q[t_idx]) * 65'(recip);
  assign scaled = sat16(prod >>> FRAC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      sing_q  <= 1'b0;
      neg_q   <= 1'b0;
      k_q     <= '0;
      for (int n = 0; n < 9; n++) begin
        a_q[n] <= '0;
        c_q[n] <= '0;
        i_q[n] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // busy is still high in the done cycle, so a coincident valid is dropped.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (valid) begin
            a_q     <= a_in;
            sing_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_COF;
          end
        end
        S_COF: begin
          c_q     <= c_d;
          state_q <= S_DET;
        end
        S_DET: begin
          if (det_d == '0) begin
            for (int n = 0; n < 9; n++) i_q[n] <= '0;
            sing_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            neg_q   <= det_d[31];
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          if (div_ready) begin
            k_q     <= '0;
            state_q <= S_SCALE;
          end
        end
        S_SCALE: begin
          i_q[k_q] <= scaled;
          if (k_q == 4'd8) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            k_q <= k_q + 4'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign I11      = i_q[0];
  assign I12      = i_q[1];
  assign I13      = i_q[2];
  assign I21      = i_q[3];
  assign I22      = i_q[4];
  assign I23      = i_q[5];
  assign I31      = i_q[6];
  assign I32      = i_q[7];
  assign I33      = i_q[8];
  assign done     = done_q;
  assign busy     = busy_q;
  assign singular = sing_q;

endmodule

// File: tb/tb_matrix_inverse_adj.sv
// Bench for matrix_inverse_adj: directed table, randomized matrices against a plain-arithmetic model, timing corners.
module tb_matrix_inverse_adj;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [15:0] a_drv [9];
  logic [15:0] i_w   [9];
  logic        done, busy, singular;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  matrix_inverse_adj dut (
    .clk(clk), .rst(rst), .valid(valid),
    .A11(a_drv[0]), .A12(a_drv[1]), .A13(a_drv[2]),
    .A21(a_drv[3]), .A22(a_drv[4]), .A23(a_drv[5]),
    .A31(a_drv[6]), .A32(a_drv[7]), .A33(a_drv[8]),
    .I11(i_w[0]), .I12(i_w[1]), .I13(i_w[2]),
    .I21(i_w[3]), .I22(i_w[4]), .I23(i_w[5]),
    .I31(i_w[6]), .I32(i_w[7]), .I33(i_w[8]),
    .done(done), .busy(busy), .singular(singular)
  );

  typedef logic [8:0][15:0] mat_t;
  typedef struct {
    string name;
    mat_t  a;
    mat_t  e;
    bit    sing;
    int    lat;
  } vec_t;

  function automatic mat_t diag(input int d0, input int d1, input int d2);
    mat_t r;
    r    = '0;
    r[0] = 16'(d0);
    r[4] = 16'(d1);
    r[8] = 16'(d2);
    return r;
  endfunction

  // Reference: textbook cofactor expansion, integer reciprocal, transposed scaling.
  function automatic void model(input mat_t m, output mat_t e, output bit sing);
    longint a [3][3];
    longint c [3][3];
    longint mn, det, absd, rec, p;
    int r0, r1, k0, k1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) a[i][j] = longint'($signed(m[i*3+j]));
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        r0 = (i == 0) ? 1 : 0;
        r1 = (i == 2) ? 1 : 2;
        k0 = (j == 0) ? 1 : 0;
        k1 = (j == 2) ? 1 : 2;
        mn = a[r0][k0] * a[r1][k1] - a[r0][k1] * a[r1][k0];
        c[i][j] = ((i + j) % 2 == 1) ? -(mn >>> 12) : (mn >>> 12);
      end
    end
    det = (a[0][0] * c[0][0] + a[0][1] * c[0][1] + a[0][2] * c[0][2]) >>> 12;
    det = longint'(int'(det));
    e = '0;
    sing = (det == 0);
    if (!sing) begin
      absd = (det < 0) ? -det : det;
      rec  = (longint'(1) << 24) / absd;
      if (det < 0) rec = -rec;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          p = (c[j][i] * rec) >>> 12;
          if (p > 32767) p = 32767;
          if (p < -32768) p = -32768;
          e[i*3+j] = 16'(p);
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic start_op(input mat_t m);
    @(negedge clk);
    for (int n = 0; n < 9; n++) a_drv[n] = m[n];
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Called at the negedge of cycle 1 after acceptance; returns the cycle in which done is seen.
  task automatic wait_done(input string nm, output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " done_seen"}, longint'(done), 1);
  endtask

  task automatic check_result(input string nm, input mat_t e, input bit sing,
                              input int lat_exp, input int lat);
    chk({nm, " latency"}, lat, lat_exp);
    chk({nm, " busy_at_done"}, longint'(busy), 1);
    chk({nm, " singular"}, longint'(singular), longint'(sing));
    for (int k = 0; k < 9; k++)
      chk($sformatf("%s I%0d%0d", nm, k / 3 + 1, k % 3 + 1),
          longint'($signed(i_w[k])), longint'($signed(e[k])));
    @(negedge clk);
    chk({nm, " done_one_cycle"}, longint'(done), 0);
    chk({nm, " busy_clear"}, longint'(busy), 0);
  endtask

  vec_t tbl[$];
  mat_t m, e, id, rows;
  bit   sing;
  int   lat, n, cnt;

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    for (int k = 0; k < 9; k++) a_drv[k] = '0;
    repeat (3) @(negedge clk);
    chk("reset done", longint'(done), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset singular", longint'(singular), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("reset I%0d", k), longint'(i_w[k]), 0);
    rst = 1'b0;

    id = diag(4096, 4096, 4096);
    rows = '0;
    for (int r = 0; r < 3; r++) begin
      rows[r*3+0] = 16'd4096;
      rows[r*3+1] = 16'd8192;
      rows[r*3+2] = 16'd12288;
    end
    tbl.push_back('{"identity", id, id, 1'b0, 37});
    tbl.push_back('{"quarter", diag(1024, 1024, 1024), diag(16384, 16384, 16384), 1'b0, 37});
    tbl.push_back('{"neg_diag", diag(-4096, 4096, 4096), diag(-4096, 4096, 4096), 1'b0, 37});
    tbl.push_back('{"saturate", diag(512, 512, 512), diag(32767, 32767, 32767), 1'b0, 37});
    tbl.push_back('{"equal_rows", rows, '0, 1'b1, 3});
    tbl.push_back('{"identity_again", id, id, 1'b0, 37});

    foreach (tbl[t]) begin
      start_op(tbl[t].a);
      chk({tbl[t].name, " busy_after_accept"}, longint'(busy), 1);
      wait_done(tbl[t].name, lat);
      check_result(tbl[t].name, tbl[t].e, tbl[t].sing, tbl[t].lat, lat);
    end

    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 9; k++) begin
        if (r % 2 == 0)
          m[k] = 16'($urandom_range(0, 65535));
        else if (k % 4 == 0)
          m[k] = 16'(int'($urandom_range(2048, 16383)) * (($urandom_range(0, 1) == 1) ? -1 : 1));
        else
          m[k] = 16'(int'($urandom_range(0, 4095)) - 2048);
      end
      model(m, e, sing);
      start_op(m);
      wait_done($sformatf("rand%0d", r), lat);
      check_result($sformatf("rand%0d", r), e, sing, sing ? 3 : 37, lat);
    end

    // valid during DIV is ignored, and so is valid in the done cycle
    start_op(diag(1024, 1024, 1024));
    n = 1;
    repeat (9) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 9; k++) a_drv[k] = id[k];
    valid = 1'b1;
    @(negedge clk);
    n++;
    valid = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("repulse latency", n, 37);
    chk("repulse I11", longint'($signed(i_w[0])), 16384);
    chk("repulse I12", longint'($signed(i_w[1])), 0);
    chk("repulse I33", longint'($signed(i_w[8])), 16384);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("coincident busy", longint'(busy), 0);
    cnt = 0;
    repeat (45) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("coincident ignored", cnt, 0);
    chk("coincident I22 held", longint'($signed(i_w[4])), 16384);

    // reset in the middle of DIV abandons the result
    start_op(id);
    n = 1;
    repeat (11) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset busy", longint'(busy), 0);
    chk("midreset done", longint'(done), 0);
    for (int k = 0; k < 9; k++) chk($sformatf("midreset I%0d", k), longint'(i_w[k]), 0);
    start_op(id);
    wait_done("after_reset", lat);
    check_result("after_reset", id, 1'b0, 37, lat);

    // rst and valid on the same edge
    for (int k = 0; k < 9; k++) a_drv[k] = id[k];
    rst   = 1'b1;
    valid = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    valid = 1'b0;
    chk("rst_valid busy", longint'(busy), 0);
    chk("rst_valid I11", longint'(i_w[0]), 0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rst_valid no_done", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_inverse_adj.md
# matrix_inverse_adj

Sequential 3x3 fixed-point matrix inverter. It computes A⁻¹ = adj(A)/det(A) in signed Q4.12 using three mechanisms:
- registered cofactors;
- an iterative restoring reciprocal of the determinant;
- a single time-shared scaling multiplier.

It sits directly upstream of `matrix_multiply1`. Its outputs I11..I33 and done pulse drive that block's P-operands and `valid`, typically for A·A⁻¹ checks or solve steps.

## Interface
Parameters:
- `W`, default 16: element width, signed.
- `FRAC`, default 12: fractional bits (Q4.12).

Ports:
- `clk`, input, 1: the single clock; everything is on its rising edge.
- `rst`, input, 1: reset is synchronous and active-high.
- `valid`, input, 1: start pulse. A11..A33 are sampled when valid=1 and the block is not busy.
- `A11`..`A33`, input, W each: source matrix, signed Q4.12.
- `I11`..`I33`, output reg, W each: inverse matrix, signed Q4.12, saturated.
- `done`, output reg, 1: one-cycle pulse; the result (or singular) is complete.
- `busy`, output reg, 1: high from acceptance until the cycle done is asserted.
- `singular`, output reg, 1: the computed det is 0. Held until the next accepted valid.

## Operation
- States: IDLE, COF, DET, DIV, SCALE.
- **IDLE**
  - valid=1: latch A, clear singular, set busy, go to COF.
  - valid=0: stay.
- **COF** (1 cycle): register the nine signed cofactors, 32-bit signed.
  - C_ij = (−1)^(i+j)·(minor product difference) >>> FRAC.
  - Example: C11 = (A22·A33 − A23·A32) >>> 12.
  - Example: C12 = −((A21·A33 − A23·A31) >>> 12).
- **DET** (1 cycle): det = (A11·C11 + A12·C12 + A13·C13) >>> FRAC.
  - Accumulate in 48 bits; keep the low 32 bits.
  - det == 0: write all I to 0, set singular=1, pulse done, clear busy, go to IDLE.
  - Otherwise: register |det| and the sign of det, init the divider, go to DIV.
- **DIV** (25 cycles): restoring unsigned division recip = 2^(2·FRAC) / |det|.
  - One quotient bit per cycle, MSB first, with a 33-bit partial remainder.
  - The quotient is 32-bit unsigned; the remainder is discarded (truncation).
  - After the 25th iteration apply the det sign to form signed 33-bit recip, then go to SCALE.
- **SCALE** (9 cycles): one element per cycle through one shared multiplier.
  - Order: I11, I12, I13, I21, …, I33.
  - I_ij = sat_W((C_ji · recip) >>> FRAC). This is the transposed cofactor, i.e. the adjugate.
  - Use a 65-bit product with an arithmetic shift.
  - sat_W clamps to [−32768, 32767].
  - On the 9th write, pulse done, clear busy, go to IDLE.
- I outputs hold their last values between operations. During SCALE they update one element per cycle; consumers use them only on or after done.
- valid while busy is ignored, with no queueing.

## Timing
- Reset values: I11..I33 = 0, done = 0, busy = 0, singular = 0, state = IDLE. All internal registers are also 0.
- valid sampled at edge k, non-singular path:
  - done is high in the cycle after edge k+36, so latency is 37 cycles.
  - busy=1 from the cycle after edge k through the done cycle inclusive.
- Singular path: done is high in the cycle after edge k+2, a latency of 3 cycles.
- A new valid is accepted in the cycle after the done cycle at the earliest. valid coincident with done is ignored, because busy is still 1.
- rst=1 in any state, including mid-DIV or mid-SCALE, returns to IDLE with all reset values on the next edge. A partial result is never completed.
- rst and valid on the same edge: rst wins and the input is not latched.
- done is never high for two consecutive cycles.

## Structure
- Package `matinv_pkg`:
  - constants FRAC_BITS=12 and DIV_ITERS=25;
  - the state enum;
  - a sat16 function.
- Sub-module `recip_div`: restoring divider.
  - Ports: clk, rst, start, divisor[31:0], quotient[31:0], ready.
  - Fixed dividend 2^24, 25-cycle latency.
- The top level holds the FSM, cofactor registers, det and sign logic, the scaling multiplier, and the output registers.

## Test plan
- Identity (diag 4096,4096,4096) -> I = identity (4096 diagonal, 0 elsewhere), singular=0, done 37 cycles after valid.
- diag(1024,1024,1024) (0.25) -> det=64, recip=262144, I diagonal = 16384 (4.0), off-diagonal 0.
- diag(−4096,4096,4096) -> I = diag(−4096,4096,4096).
- diag(512,512,512) -> I diagonal saturates to 32767. Three equal rows (4096,8192,12288) -> singular=1, all I=0, done 3 cycles after valid.
- valid re-pulsed during DIV -> ignored; result matches the first matrix and exactly one done pulse occurs.
- rst asserted at DIV cycle 10, then valid with identity -> all outputs 0 after reset, then the identity result 37 cycles later.
